// File: rtl/ring_osc_sweep_ctrl.sv
// Ring-oscillator frequency sweep controller: enables the ring, lets it settle,
// counts synchronized osc_in rising edges over a fixed gate window per tap.
module ring_osc_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int GATE_CYCLES   = 256,
  parameter int CNT_W         = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sweep,
  input  logic [2:0]       tap_sel,
  input  logic             osc_in,
  output logic             osc_en,
  output logic [2:0]       tap,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [2:0]       result_tap,
  output logic             result_valid,
  output logic             overflow,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] REPORT  = 2'd3;

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]       state;
  logic [CYC_W-1:0] cyc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             sweep_q;
  logic             sync1, sync2, sync3;
  logic             rise;

  // osc_in is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise   = sync2 & ~sync3;
  assign osc_en = (state == SETTLE) || (state == MEASURE);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cyc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      sweep_q      <= 1'b0;
      tap          <= 3'd0;
      result       <= '0;
      result_tap   <= 3'd0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      done         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            sweep_q <= sweep;
            tap     <= sweep ? 3'd0 : tap_sel;
            cyc     <= '0;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            cnt <= '0;
            ovf <= 1'b0;
            if (cyc == SETTLE_LAST) begin
              cyc   <= '0;
              state <= MEASURE;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
        end
        MEASURE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // Saturate rather than wrap so a too-fast ring is flagged, not aliased
            if (rise) begin
              if (cnt == CNT_MAX) ovf <= 1'b1;
              else                cnt <= cnt + 1'b1;
            end
            if (cyc == GATE_LAST) begin
              cyc   <= '0;
              state <= REPORT;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
        end
        default: begin
          // REPORT publishes even when aborted; abort only stops further taps
          result       <= cnt;
          result_tap   <= tap;
          overflow     <= ovf;
          result_valid <= 1'b1;
          if (!abort && sweep_q && (tap != 3'd7)) begin
            tap   <= tap + 3'd1;
            cyc   <= '0;
            state <= SETTLE;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_sweep_ctrl.sv
// Directed bench for ring_osc_sweep_ctrl: a 12-bit instance for the main
// scenarios and a 3-bit-counter instance for saturation.
module tb_ring_osc_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        abort = 1'b0;
  logic        sweep = 1'b0;
  logic [2:0]  tap_sel = 3'd0;
  logic        osc = 1'b0;

  logic        osc_en_a, busy_a, result_valid_a, overflow_a, done_a;
  logic [2:0]  tap_a, result_tap_a;
  logic [11:0] result_a;

  logic        osc_en_b, busy_b, result_valid_b, overflow_b, done_b;
  logic [2:0]  tap_b, result_tap_b;
  logic [2:0]  result_b;

  int n_checks = 0;
  int n_fail   = 0;
  int hp       = 2;
  int oc       = 0;

  always #5 clk = ~clk;

  ring_osc_sweep_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .sweep(sweep),
    .tap_sel(tap_sel), .osc_in(osc), .osc_en(osc_en_a), .tap(tap_a), .busy(busy_a),
    .result(result_a), .result_tap(result_tap_a), .result_valid(result_valid_a),
    .overflow(overflow_a), .done(done_a));

  ring_osc_sweep_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .sweep(sweep),
    .tap_sel(tap_sel), .osc_in(osc), .osc_en(osc_en_b), .tap(tap_b), .busy(busy_b),
    .result(result_b), .result_tap(result_tap_b), .result_valid(result_valid_b),
    .overflow(overflow_b), .done(done_b));

  // Oscillator model: toggles every hp clk cycles, changing on falling edges
  initial begin
    forever begin
      @(negedge clk);
      if (oc >= hp - 1) begin
        oc  = 0;
        osc = ~osc;
      end else begin
        oc = oc + 1;
      end
    end
  end

  task automatic pulse_start_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({osc_en_a, tap_a, busy_a, result_a, result_tap_a, result_valid_a, overflow_a, done_a} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got osc_en=%b tap=%0d busy=%b result=%0d rtap=%0d rv=%b ovf=%b done=%b, want all 0",
               osc_en_a, tap_a, busy_a, result_a, result_tap_a, result_valid_a, overflow_a, done_a);
    end
    n_checks++;
    if (busy_b !== 1'b0 || result_b !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_b: got busy=%b result=%0d, want 0 0", busy_b, result_b);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    tap_sel = 3'd5;
    sweep   = 1'b0;
    hp      = 2;
    pulse_start_a();
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_checks++;
        if (busy_a !== 1'b1 || osc_en_a !== 1'b1 || tap_a !== 3'd5) begin
          n_fail++;
          $display("FAIL single_settle: got busy=%b osc_en=%b tap=%0d, want 1 1 5", busy_a, osc_en_a, tap_a);
        end
      end
      if (result_valid_a) break;
    end
    n_checks++;
    if (n !== 21) begin n_fail++; $display("FAIL single_latency: got %0d, want 21", n); end
    n_checks++;
    if (result_a !== 12'd4 || result_tap_a !== 3'd5 || overflow_a !== 1'b0 || done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: got result=%0d rtap=%0d ovf=%b done=%b, want 4 5 0 1",
               result_a, result_tap_a, overflow_a, done_a);
    end
    @(negedge clk);
    n_checks++;
    if (result_valid_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0 || result_a !== 12'd4 || result_tap_a !== 3'd5) begin
      n_fail++;
      $display("FAIL single_hold: got rv=%b done=%b busy=%b result=%0d rtap=%0d, want 0 0 0 4 5",
               result_valid_a, done_a, busy_a, result_a, result_tap_a);
    end
  endtask

  task automatic test_sweep();
    int k = 0;
    int low = 0;
    int n;
    sweep   = 1'b1;
    tap_sel = 3'd6;
    pulse_start_a();
    for (n = 1; n <= 250; n++) begin
      @(negedge clk);
      if (busy_a && !osc_en_a) low++;
      if (result_valid_a) begin
        n_checks++;
        if (result_tap_a !== k[2:0] || result_a !== 12'd4 || n !== 21 * (k + 1) || done_a !== (k == 7)) begin
          n_fail++;
          $display("FAIL sweep_pulse%0d: got rtap=%0d result=%0d cycle=%0d done=%b, want %0d 4 %0d %b",
                   k, result_tap_a, result_a, n, done_a, k, 21 * (k + 1), (k == 7));
        end
        k++;
        if (done_a) break;
      end else begin
        n_checks++;
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL sweep_stray_done: cycle %0d got done=1, want 0", n); end
      end
    end
    n_checks++;
    if (k !== 8 || low !== 8) begin
      n_fail++;
      $display("FAIL sweep_totals: got pulses=%0d osc_low_cycles=%0d, want 8 8", k, low);
    end
    sweep = 1'b0;
  endtask

  task automatic test_abort();
    int hits = 0;
    tap_sel = 3'd2;
    pulse_start_a();
    repeat (13) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1 || osc_en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got busy=%b osc_en=%b, want 1 1", busy_a, osc_en_a);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || osc_en_a !== 1'b0 || result_valid_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b osc_en=%b rv=%b done=%b, want 0 0 0 0",
               busy_a, osc_en_a, result_valid_a, done_a);
    end
    repeat (30) begin
      @(negedge clk);
      if (result_valid_a || done_a || busy_a) hits++;
    end
    n_checks++;
    if (hits !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles, want 0", hits); end
    n_checks++;
    if (result_a !== 12'd4 || result_tap_a !== 3'd7 || overflow_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_keep: got result=%0d rtap=%0d ovf=%b, want 4 7 0", result_a, result_tap_a, overflow_a);
    end
  endtask

  task automatic test_busy_start();
    int n;
    int extra = 0;
    tap_sel = 3'd1;
    sweep   = 1'b0;
    pulse_start_a();
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    tap_sel = 3'd6;
    sweep   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (n = 6; n <= 60; n++) begin
      @(negedge clk);
      if (result_valid_a) break;
    end
    n_checks++;
    if (n !== 21 || result_tap_a !== 3'd1 || done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_run: got cycle=%0d rtap=%0d done=%b, want 21 1 1", n, result_tap_a, done_a);
    end
    repeat (25) begin
      @(negedge clk);
      if (busy_a || result_valid_a) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL busy_start_ignored: got %0d active cycles, want 0", extra); end
    sweep = 1'b0;
  endtask

  task automatic test_start_abort();
    int act = 0;
    @(negedge clk);
    start_a = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort   = 1'b0;
    n_checks++;
    if (busy_a !== 1'b0 || osc_en_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b osc_en=%b, want 0 0", busy_a, osc_en_a);
    end
    repeat (5) begin
      @(negedge clk);
      if (busy_a) act++;
    end
    n_checks++;
    if (act !== 0) begin n_fail++; $display("FAIL start_abort_stay: got %0d busy cycles, want 0", act); end
  endtask

  task automatic test_saturation();
    int n;
    hp = 1;
    repeat (2) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (result_valid_b) break;
    end
    n_checks++;
    if (n !== 21 || result_b !== 3'd7 || overflow_b !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_fast: got cycle=%0d result=%0d ovf=%b, want 21 7 1", n, result_b, overflow_b);
    end
    hp = 4;
    repeat (3) @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (result_valid_b) break;
    end
    n_checks++;
    if (n !== 21 || result_b !== 3'd2 || overflow_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: got cycle=%0d result=%0d ovf=%b, want 21 2 0", n, result_b, overflow_b);
    end
    hp = 2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    sweep = 1'b1;
    pulse_start_a();
    repeat (64) @(negedge clk);
    n_checks++;
    if (tap_a !== 3'd3 || busy_a !== 1'b1 || osc_en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got tap=%0d busy=%b osc_en=%b, want 3 1 1", tap_a, busy_a, osc_en_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({osc_en_a, tap_a, busy_a, result_a, result_tap_a, result_valid_a, overflow_a, done_a} !== 22'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got osc_en=%b tap=%0d busy=%b result=%0d rtap=%0d rv=%b ovf=%b done=%b, want all 0",
               osc_en_a, tap_a, busy_a, result_a, result_tap_a, result_valid_a, overflow_a, done_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy=%b, want 0", busy_a); end
    pulse_start_a();
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (result_valid_a) break;
    end
    n_checks++;
    if (n !== 21 || result_tap_a !== 3'd0 || result_a !== 12'd4 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_rerun: got cycle=%0d rtap=%0d result=%0d done=%b, want 21 0 4 0",
               n, result_tap_a, result_a, done_a);
    end
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done_a) break;
    end
    n_checks++;
    if (done_a !== 1'b1 || result_tap_a !== 3'd7) begin
      n_fail++;
      $display("FAIL midreset_done: got done=%b rtap=%0d, want 1 7", done_a, result_tap_a);
    end
    sweep = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_abort();
    test_busy_start();
    test_start_abort();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_osc_sweep_ctrl.md
RING_OSC_SWEEP_CTRL -- requirements
Module: ring_osc_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: clk cycles the ring runs enabled before counting begins; legal range >=1.
REQ-002 Parameter GATE_CYCLES, default 256: clk cycles in the measurement window; legal range >=1.
REQ-003 Parameter CNT_W, default 12: edge-counter and result width.
REQ-004 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level sampled in IDLE; begins a run.
REQ-008 abort  input  1  synchronous abort of any run in progress.
REQ-009 sweep  input  1  sampled with start; 1 = measure taps 0..7, 0 = single tap.
REQ-010 tap_sel  input  3  tap for single-tap mode, sampled with start.
REQ-011 osc_in  input  1  asynchronous ring-oscillator output.
REQ-012 osc_en  output  1  ring-oscillator enable.
REQ-013 tap  output  3  tap select driven to the ring.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 result  output  CNT_W  osc_in rising-edge count for the last completed window.
REQ-016 result_tap  output  3  tap that result belongs to.
REQ-017 result_valid  output  1  one-cycle pulse when result/result_tap update.
REQ-018 overflow  output  1  the count for the current result saturated.
REQ-019 done  output  1  one-cycle pulse at the end of a complete run.

Function
REQ-020 osc_in SHALL pass through a 2-flop synchronizer plus a third flop; a rising edge is counted when flop2=1 and flop3=0.
REQ-021 Accurate counts SHALL require an osc_in frequency below clk/2; higher rates are out of scope and need no defined count.
REQ-022 The FSM SHALL have the states IDLE, SETTLE, MEASURE and REPORT.
REQ-023 IDLE: osc_en=0 and busy=0; when start=1 and abort=0, latch sweep, set tap = sweep ? 0 : tap_sel, then go to SETTLE.
REQ-024 SETTLE: osc_en=1; the edge counter is held at 0; remain exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-025 MEASURE: osc_en=1; count detected edges for exactly GATE_CYCLES cycles, then go to REPORT.
REQ-026 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL set an internal overflow flag; it SHALL never wrap.
REQ-027 REPORT lasts 1 cycle with osc_en=0.
REQ-028 On REPORT, result, result_tap and overflow are loaded and result_valid=1.
REQ-029 An edge detected on the final MEASURE cycle SHALL be included in result.
REQ-030 From REPORT, if sweep is latched and tap<7, tap increments by 1 and the FSM returns to SETTLE.
REQ-031 From REPORT in every other case, done=1 in that same cycle and the FSM returns to IDLE.
REQ-032 result_valid SHALL rise exactly 1+SETTLE_CYCLES+GATE_CYCLES clk edges after the edge that samples start.
REQ-033 result, result_tap and overflow SHALL hold between REPORT cycles.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 tap_sel and sweep changes while busy=1 SHALL have no effect on the current run.
REQ-036 abort=1 in any non-IDLE state SHALL move the FSM to IDLE on the next edge with osc_en=0.
REQ-037 An aborted run SHALL produce no result_valid and no done.
REQ-038 An aborted run SHALL leave result, result_tap and overflow unchanged.
REQ-039 If abort=1 in the REPORT cycle, that REPORT's result_valid and done still fire, and the next state is IDLE.
REQ-040 If start=1 and abort=1 together in IDLE, the FSM SHALL stay in IDLE.
REQ-041 tap SHALL remain stable throughout SETTLE and MEASURE.

Reset
REQ-042 rst_n=0 SHALL asynchronously force state=IDLE and clear all output registers.
REQ-043 Outputs under reset: osc_en=0, tap=0, busy=0, result=0, result_tap=0, result_valid=0, overflow=0, done=0.
REQ-044 rst_n=0 SHALL also clear the synchronizer flops, the counters and the latched sweep.
REQ-045 Reset asserted mid-run SHALL discard the run; after release, the block waits in IDLE for a new start.

Verification
REQ-046 Single tap: SETTLE=4, GATE=16, CNT_W=12, tap_sel=5, osc_in period 4 clk, start pulse -> result_valid 21 cycles later, result=4, result_tap=5, overflow=0, done in the same cycle.
REQ-047 Sweep: same parameters, sweep=1 -> 8 result_valid pulses with result_tap 0..7 in order, osc_en low 1 cycle between taps, done only with the eighth pulse.
REQ-048 Saturation: CNT_W=3, GATE=16, osc_in period 2 clk -> result=7, overflow=1; a following slow-osc run clears overflow.
REQ-049 Abort: assert abort in cycle 10 of MEASURE -> IDLE next cycle, osc_en=0, no result_valid or done, result unchanged from the prior run.
REQ-050 Start while busy and start+abort together in IDLE -> both ignored; the run completes unaffected / the block stays in IDLE.
REQ-051 Reset in SETTLE of tap 3 during a sweep -> all outputs 0 immediately; a new start after release runs normally from tap 0.
